// File: rtl/knn_batch_ctrl.sv
// k-NN batch controller: streams search batches from memory through the
// distance/sort engine and keeps the global best and second-best matches.
module knn_batch_ctrl #(
    parameter int MEM_AW  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [63:0]       query,
    input  logic [4:0]        num_batches,
    input  logic [MEM_AW-1:0] base_addr,
    output logic              mem_rd_en,
    output logic [MEM_AW-1:0] mem_rd_addr,
    input  logic [511:0]      mem_rd_data,
    output logic              eng_in_valid,
    output logic [63:0]       eng_query,
    output logic [511:0]      eng_search,
    input  logic              eng_out_valid,
    input  logic [2:0]        eng_addr_1st,
    input  logic [2:0]        eng_addr_2nd,
    input  logic [31:0]       eng_dist_1st,
    input  logic [31:0]       eng_dist_2nd,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [6:0]        res_idx_1st,
    output logic [6:0]        res_idx_2nd,
    output logic [31:0]       res_dist_1st,
    output logic [31:0]       res_dist_2nd,
    output logic              res_err,
    output logic              busy
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [63:0]       q_r;
    logic [4:0]        nb_r;
    logic [MEM_AW-1:0] base_r;
    logic [4:0]        bcnt;
    logic [511:0]      srch_r;
    logic [31:0]       g1_d;
    logic [31:0]       g2_d;
    logic [6:0]        g1_i;
    logic [6:0]        g2_i;
    logic              err_r;
    logic [TW-1:0]     tmr;

    logic              last_b;
    logic              tmo;
    logic [31:0]       m1_d;
    logic [31:0]       m2_d;
    logic [6:0]        m1_i;
    logic [6:0]        m2_i;
    logic [31:0]       cd [4];
    logic [6:0]        ci [4];
    logic [1:0]        rk [4];

    assign last_b = (bcnt == nb_r - 5'd1);
    assign tmo    = (tmr == TW'(TIMEOUT - 1));

    assign eng_query    = q_r;
    assign eng_search   = srch_r;
    assign res_idx_1st  = g1_i;
    assign res_idx_2nd  = g2_i;
    assign res_dist_1st = g1_d;
    assign res_dist_2nd = g2_d;
    assign res_err      = err_r;
    assign mem_rd_addr  = mem_rd_en ? base_r + MEM_AW'(bcnt) : '0;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and control strobes
    always_comb begin
        state_nx     = state;
        start_ready  = 1'b0;
        busy         = 1'b1;
        mem_rd_en    = 1'b0;
        eng_in_valid = 1'b0;
        res_valid    = 1'b0;
        unique case (state)
            IDLE: begin
                start_ready = 1'b1;
                busy        = 1'b0;
                if (start_valid) begin
                    state_nx = (num_batches == 5'd0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                mem_rd_en = 1'b1;
                state_nx  = LOAD;
            end
            LOAD: begin
                state_nx = ISSUE;
            end
            ISSUE: begin
                eng_in_valid = 1'b1;
                state_nx     = WAIT;
            end
            WAIT: begin
                if (eng_out_valid) begin
                    state_nx = last_b ? DONE : FETCH;
                end else if (tmo) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Stable top-2 of {g1, g2, e1, e2}: lower position wins ties
    always_comb begin
        cd[0] = g1_d;
        ci[0] = g1_i;
        cd[1] = g2_d;
        ci[1] = g2_i;
        cd[2] = eng_dist_1st;
        ci[2] = {bcnt[3:0], eng_addr_1st};
        cd[3] = eng_dist_2nd;
        ci[3] = {bcnt[3:0], eng_addr_2nd};
        m1_d  = '1;
        m1_i  = '0;
        m2_d  = '1;
        m2_i  = '0;
        for (int i = 0; i < 4; i++) begin
            rk[i] = 2'd0;
            for (int j = 0; j < 4; j++) begin
                if (j != i && (cd[j] < cd[i] ||
                    (cd[j] == cd[i] && j < i))) begin
                    rk[i] = rk[i] + 2'd1;
                end
            end
            if (rk[i] == 2'd0) begin
                m1_d = cd[i];
                m1_i = ci[i];
            end
            if (rk[i] == 2'd1) begin
                m2_d = cd[i];
                m2_i = ci[i];
            end
        end
    end

    // Job context, search buffer, running result and wait timer
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r    <= '0;
            nb_r   <= '0;
            base_r <= '0;
            bcnt   <= '0;
            srch_r <= '0;
            g1_d   <= '1;
            g2_d   <= '1;
            g1_i   <= '0;
            g2_i   <= '0;
            err_r  <= 1'b0;
            tmr    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_valid) begin
                        q_r    <= query;
                        nb_r   <= num_batches;
                        base_r <= base_addr;
                        bcnt   <= '0;
                        g1_d   <= '1;
                        g2_d   <= '1;
                        g1_i   <= '0;
                        g2_i   <= '0;
                        err_r  <= (num_batches == 5'd0);
                    end
                end
                LOAD: begin
                    srch_r <= mem_rd_data;
                end
                ISSUE: begin
                    tmr <= '0;
                end
                WAIT: begin
                    if (eng_out_valid) begin
                        g1_d <= m1_d;
                        g1_i <= m1_i;
                        g2_d <= m2_d;
                        g2_i <= m2_i;
                        if (!last_b) begin
                            bcnt <= bcnt + 5'd1;
                        end
                    end else if (tmo) begin
                        err_r <= 1'b1;
                    end else begin
                        tmr <= tmr + TW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_knn_batch_ctrl.sv
// Self-checking bench for knn_batch_ctrl: memory and engine models plus a
// top-2 reference computed over the whole job's candidate list.
module tb_knn_batch_ctrl;

    localparam int AW = 8;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_valid = 1'b0;
    logic          start_ready;
    logic [63:0]   query = '0;
    logic [4:0]    num_batches = '0;
    logic [AW-1:0] base_addr = '0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [511:0]  mem_rd_data = '0;
    logic          eng_in_valid;
    logic [63:0]   eng_query;
    logic [511:0]  eng_search;
    logic          eng_out_valid = 1'b0;
    logic [2:0]    eng_addr_1st = '0;
    logic [2:0]    eng_addr_2nd = '0;
    logic [31:0]   eng_dist_1st = '0;
    logic [31:0]   eng_dist_2nd = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [6:0]    res_idx_1st;
    logic [6:0]    res_idx_2nd;
    logic [31:0]   res_dist_1st;
    logic [31:0]   res_dist_2nd;
    logic          res_err;
    logic          busy;

    knn_batch_ctrl #(.MEM_AW(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .start_valid(start_valid), .start_ready(start_ready),
        .query(query), .num_batches(num_batches), .base_addr(base_addr),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data),
        .eng_in_valid(eng_in_valid), .eng_query(eng_query),
        .eng_search(eng_search), .eng_out_valid(eng_out_valid),
        .eng_addr_1st(eng_addr_1st), .eng_addr_2nd(eng_addr_2nd),
        .eng_dist_1st(eng_dist_1st), .eng_dist_2nd(eng_dist_2nd),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_idx_1st(res_idx_1st), .res_idx_2nd(res_idx_2nd),
        .res_dist_1st(res_dist_1st), .res_dist_2nd(res_dist_2nd),
        .res_err(res_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [511:0]  mem [256];
    int unsigned   td1 [16];
    int unsigned   td2 [16];
    logic [2:0]    ta1 [16];
    logic [2:0]    ta2 [16];
    int            eng_lat = 1;
    bit            eng_mute = 1'b0;
    bit            spur = 1'b0;
    int            pend = 0;
    int            eng_b = 0;
    int            eng_cur = 0;
    int            rd_cnt = 0;
    logic [AW-1:0] job_base = '0;
    logic [63:0]   job_q = '0;
    bit            rd_pend = 1'b0;
    logic [AW-1:0] rd_paddr = '0;
    logic [511:0]  held_s = '0;
    logic [63:0]   held_q = '0;

    task automatic chk(input string tag, input logic [511:0] obs,
                       input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Memory with one-cycle read latency, engine with fixed latency per job
    always @(negedge clk) begin
        mem_rd_data = rd_pend ? mem[rd_paddr] : rnd512();
        rd_pend = 1'b0;
        if (mem_rd_en) begin
            chk("rd_addr", mem_rd_addr, AW'(job_base + AW'(rd_cnt)));
            chk("rd_and_issue", eng_in_valid, 1'b0);
            rd_pend  = 1'b1;
            rd_paddr = mem_rd_addr;
            rd_cnt++;
        end
        eng_out_valid = 1'b0;
        eng_addr_1st  = 3'($urandom);
        eng_addr_2nd  = 3'($urandom);
        eng_dist_1st  = $urandom;
        eng_dist_2nd  = $urandom;
        if (pend > 0) begin
            if (busy) begin
                chk("eng_q_hold", eng_query, held_q);
                chk("eng_s_hold", eng_search, held_s);
            end
            pend--;
            if (pend == 0) begin
                eng_out_valid = 1'b1;
                eng_addr_1st  = ta1[eng_cur];
                eng_addr_2nd  = ta2[eng_cur];
                eng_dist_1st  = td1[eng_cur];
                eng_dist_2nd  = td2[eng_cur];
            end
        end
        if (spur) begin
            eng_out_valid = 1'b1;
            eng_addr_1st  = 3'd7;
            eng_addr_2nd  = 3'd6;
            eng_dist_1st  = 32'd0;
            eng_dist_2nd  = 32'd0;
        end
        if (eng_in_valid) begin
            chk("one_outstanding", pend, 0);
            chk("eng_query", eng_query, job_q);
            chk("eng_search", eng_search, mem[AW'(job_base + AW'(eng_b))]);
            held_q  = eng_query;
            held_s  = eng_search;
            eng_cur = eng_b;
            if (!eng_mute) pend = eng_lat;
            eng_b++;
        end
    end

    // Top-2 over the placeholders followed by every engine candidate in
    // arrival order; earlier entries win ties.
    task automatic model(input int nb, input bit mute,
                         output logic [31:0] d1, output logic [6:0] i1,
                         output logic [31:0] d2, output logic [6:0] i2);
        logic [31:0] cd [$];
        logic [6:0]  ci [$];
        int b1;
        int b2;
        cd.push_back(32'hFFFF_FFFF); ci.push_back(7'd0);
        cd.push_back(32'hFFFF_FFFF); ci.push_back(7'd0);
        if (!mute) begin
            for (int b = 0; b < nb; b++) begin
                cd.push_back(td1[b]); ci.push_back(7'(b * 8 + int'(ta1[b])));
                cd.push_back(td2[b]); ci.push_back(7'(b * 8 + int'(ta2[b])));
            end
        end
        b1 = 0;
        for (int i = 1; i < cd.size(); i++) if (cd[i] < cd[b1]) b1 = i;
        b2 = (b1 == 0) ? 1 : 0;
        for (int i = 0; i < cd.size(); i++)
            if (i != b1 && cd[i] < cd[b2]) b2 = i;
        d1 = cd[b1]; i1 = ci[b1];
        d2 = cd[b2]; i2 = ci[b2];
    endtask

    task automatic fill_rand(input int maxd);
        for (int b = 0; b < 16; b++) begin
            td1[b] = $urandom_range(0, maxd);
            td2[b] = $urandom_range(0, maxd);
            ta1[b] = 3'($urandom_range(0, 7));
            ta2[b] = 3'($urandom_range(0, 7));
        end
    endtask

    task automatic run_job(input string nm, input int nb,
                           input logic [AW-1:0] base, input int lat,
                           input bit mute);
        logic [31:0] xd1;
        logic [31:0] xd2;
        logic [6:0]  xi1;
        logic [6:0]  xi2;
        logic [63:0] q;
        int xlat;
        int xbat;
        int n;
        model(nb, mute, xd1, xi1, xd2, xi2);
        xlat = (nb == 0) ? 0 : (mute ? 3 + TO : nb * (3 + lat));
        xbat = (nb == 0) ? 0 : (mute ? 1 : nb);
        q = {$urandom, $urandom};
        @(negedge clk);
        eng_lat = lat; eng_mute = mute; job_base = base; job_q = q;
        rd_cnt = 0; eng_b = 0;
        chk({nm, ".start_ready"}, start_ready, 1'b1);
        start_valid = 1'b1; query = q;
        num_batches = 5'(nb); base_addr = base;
        @(negedge clk);
        start_valid = 1'b0; query = {$urandom, $urandom};
        num_batches = 5'($urandom); base_addr = AW'($urandom);
        n = 0;
        while (!res_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, ".latency"}, n, xlat);
        chk({nm, ".err"}, res_err, (nb == 0) || mute);
        chk({nm, ".idx1"}, res_idx_1st, xi1);
        chk({nm, ".idx2"}, res_idx_2nd, xi2);
        chk({nm, ".dist1"}, res_dist_1st, xd1);
        chk({nm, ".dist2"}, res_dist_2nd, xd2);
        chk({nm, ".reads"}, rd_cnt, xbat);
        chk({nm, ".issues"}, eng_b, xbat);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #2 spur = (k < 2);
            @(negedge clk);
            chk({nm, ".hold_valid"}, res_valid, 1'b1);
            chk({nm, ".hold_idx1"}, res_idx_1st, xi1);
            chk({nm, ".hold_dist2"}, res_dist_2nd, xd2);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk({nm, ".valid_drop"}, res_valid, 1'b0);
        chk({nm, ".idle_ready"}, start_ready, 1'b1);
        chk({nm, ".idle_busy"}, busy, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem[i] = rnd512();
        repeat (2) @(negedge clk);
        chk("rst.start_ready", start_ready, 1'b1);
        chk("rst.busy", busy, 1'b0);
        chk("rst.mem_rd_en", mem_rd_en, 1'b0);
        chk("rst.mem_rd_addr", mem_rd_addr, '0);
        chk("rst.eng_in_valid", eng_in_valid, 1'b0);
        chk("rst.res_valid", res_valid, 1'b0);
        chk("rst.res_err", res_err, 1'b0);
        chk("rst.idx1", res_idx_1st, '0);
        chk("rst.idx2", res_idx_2nd, '0);
        chk("rst.dist1", res_dist_1st, 32'hFFFF_FFFF);
        chk("rst.dist2", res_dist_2nd, 32'hFFFF_FFFF);
        chk("rst.eng_query", eng_query, '0);
        chk("rst.eng_search", eng_search, '0);
        rst = 1'b0;

        fill_rand(100);
        td1[0] = 3; ta1[0] = 3'd5; td2[0] = 7; ta2[0] = 3'd2;
        run_job("single", 1, 8'h10, 4, 1'b0);

        fill_rand(100);
        td1[0] = 9; ta1[0] = 3'd1; td2[0] = 4; ta2[0] = 3'd6;
        td1[1] = 2; ta1[1] = 3'd3; td2[1] = 8; ta2[1] = 3'd7;
        td1[2] = 4; ta1[2] = 3'd0; td2[2] = 1; ta2[2] = 3'd4;
        run_job("three", 3, 8'h40, 2, 1'b0);

        fill_rand(100);
        td1[0] = 5; ta1[0] = 3'd3; td2[0] = 20; ta2[0] = 3'd6;
        td1[1] = 5; ta1[1] = 3'd0; td2[1] = 30; ta2[1] = 3'd1;
        run_job("tie", 2, 8'h22, 3, 1'b0);

        fill_rand(50);
        run_job("wrap", 4, 8'hFE, 1, 1'b0);

        fill_rand(50);
        run_job("timeout", 3, 8'h05, 1, 1'b1);

        run_job("zero", 0, 8'h07, 1, 1'b0);

        fill_rand(20);
        run_job("full16", 16, 8'hF8, 2, 1'b0);

        fill_rand(50);
        @(negedge clk);
        eng_lat = 8; eng_mute = 1'b0; job_base = 8'h30; job_q = 64'h1234;
        rd_cnt = 0; eng_b = 0;
        start_valid = 1'b1; query = 64'h1234;
        num_batches = 5'd2; base_addr = 8'h30;
        @(negedge clk);
        start_valid = 1'b0;
        n = 0;
        while (eng_b < 1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("midrst.issued", eng_b, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("midrst.start_ready", start_ready, 1'b1);
            chk("midrst.busy", busy, 1'b0);
            chk("midrst.res_valid", res_valid, 1'b0);
            chk("midrst.mem_rd_en", mem_rd_en, 1'b0);
            chk("midrst.dist1", res_dist_1st, 32'hFFFF_FFFF);
        end
        fill_rand(50);
        run_job("after_rst", 2, 8'h31, 3, 1'b0);

        for (int j = 0; j < 10; j++) begin
            fill_rand(15);
            run_job($sformatf("rand%0d", j), $urandom_range(1, 16),
                    AW'($urandom), $urandom_range(1, 8), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
